// File: rtl/viterbi_acs_ctrl.sv
// viterbi_acs_ctrl: frame-level sequencer for the Viterbi BMU/ACS datapath.
// Accepts one symbol per trellis step, issues it to the BMU/ACS, optionally
// normalises path metrics, and triggers traceback after FRAME_LEN steps.
// Optional feature macro: VITERBI_NORM_EN (path-metric normalisation).
module viterbi_acs_ctrl #(
  parameter int unsigned FRAME_LEN   = 8,
  parameter int unsigned SYM_W       = 2,
  parameter int unsigned PM_W        = 4,
  parameter int unsigned NORM_THRESH = 12
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      sym_valid,
  input  logic [SYM_W-1:0]                          sym_data,
  output logic                                      sym_ready,
  output logic                                      bmu_valid,
  output logic [SYM_W-1:0]                          bmu_sym,
  output logic                                      first_step,
  input  logic                                      acs_done,
  input  logic [PM_W-1:0]                           pm_00,
  input  logic [PM_W-1:0]                           pm_01,
  input  logic [PM_W-1:0]                           pm_10,
  input  logic [PM_W-1:0]                           pm_11,
  output logic                                      norm_en,
  output logic [PM_W-1:0]                           norm_val,
  output logic [((FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1)-1:0] step_cnt,
  output logic                                      tb_start,
  input  logic                                      tb_done,
  output logic                                      frame_done
);

  localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACS  = 3'd2,
    NORM      = 3'd3,
    TRACEBACK = 3'd4
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   step_d;
  logic [SYM_W-1:0]   sym_d;
  logic               ready_d, bmu_valid_d, first_d, norm_en_d, tb_start_d, frame_done_d;
  logic [PM_W-1:0]    norm_val_d;
  logic               last_step;
  logic               do_norm;
  logic [PM_W-1:0]    pm_min;

  assign last_step = (step_cnt == CNT_W'(FRAME_LEN - 1));

`ifdef VITERBI_NORM_EN
  logic [3:0][PM_W-1:0] pm_q;
  logic [PM_W-1:0]      pm_max;

  // Capture the ACS metrics on the accepted acs_done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pm_q <= '0;
    end else if (state == WAIT_ACS && acs_done) begin
      pm_q <= {pm_11, pm_10, pm_01, pm_00};
    end
  end

  // Unsigned min/max over the latched metrics
  always_comb begin
    pm_max = pm_q[0];
    pm_min = pm_q[0];
    for (int i = 1; i < 4; i++) begin
      if (pm_q[i] > pm_max) pm_max = pm_q[i];
      if (pm_q[i] < pm_min) pm_min = pm_q[i];
    end
  end

  assign do_norm = (pm_max >= PM_W'(NORM_THRESH));
`else
  logic unused_pm;
  assign unused_pm = ^{pm_00, pm_01, pm_10, pm_11};
  assign pm_min    = '0;
  assign do_norm   = 1'b0;
`endif

  // Next-state and next-output decode
  always_comb begin
    state_d      = state;
    step_d       = step_cnt;
    sym_d        = bmu_sym;
    bmu_valid_d  = 1'b0;
    first_d      = 1'b0;
    norm_en_d    = 1'b0;
    norm_val_d   = '0;
    tb_start_d   = 1'b0;
    frame_done_d = 1'b0;
    case (state)
      IDLE: begin
        if (sym_valid) begin
          sym_d       = sym_data;
          bmu_valid_d = 1'b1;
          first_d     = (step_cnt == '0);
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_ACS;
      WAIT_ACS: begin
        if (acs_done) state_d = NORM;
      end
      NORM: begin
        norm_en_d  = do_norm;
        norm_val_d = do_norm ? pm_min : '0;
        if (last_step) begin
          tb_start_d = 1'b1;
          state_d    = TRACEBACK;
        end else begin
          step_d  = step_cnt + CNT_W'(1);
          state_d = IDLE;
        end
      end
      TRACEBACK: begin
        // tb_done coincident with our own tb_start cannot belong to this frame
        if (tb_done && !tb_start) begin
          frame_done_d = 1'b1;
          step_d       = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      step_cnt   <= '0;
      bmu_sym    <= '0;
      sym_ready  <= 1'b1;
      bmu_valid  <= 1'b0;
      first_step <= 1'b0;
      norm_en    <= 1'b0;
      norm_val   <= '0;
      tb_start   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      step_cnt   <= step_d;
      bmu_sym    <= sym_d;
      sym_ready  <= ready_d;
      bmu_valid  <= bmu_valid_d;
      first_step <= first_d;
      norm_en    <= norm_en_d;
      norm_val   <= norm_val_d;
      tb_start   <= tb_start_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: doc/viterbi_acs_ctrl.md
# viterbi_acs_ctrl

Frame-level sequencer for the Viterbi decoder's branch-metric and add-compare-select datapath. It accepts received symbols over a valid/ready handshake and issues one trellis step at a time to the branch-metric unit and the ACS stage, selecting the first-stage ACS on step 0 of each frame. After each step it optionally normalises the path metrics. After `FRAME_LEN` steps it triggers traceback and holds off input until traceback completes.

## Interface
Parameters:
- `FRAME_LEN`, 8, trellis steps per frame; must be ≥2; matches the path-history width.
- `SYM_W`, 2, received symbol width.
- `PM_W`, 4, path-metric width.
- `NORM_THRESH`, 12, normalisation trigger level; must be < 2^PM_W.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `sym_valid` in 1: upstream symbol valid.
- `sym_data` in SYM_W: received symbol.
- `sym_ready` out 1: controller can accept a symbol.
- `bmu_valid` out 1: one-cycle strobe to the branch-metric unit.
- `bmu_sym` out SYM_W: registered copy of the accepted symbol, held until the next accept.
- `first_step` out 1: qualifies `bmu_valid`; high when step 0 is issued, selecting the first-stage ACS.
- `acs_done` in 1: ACS `valid_out` pulse.
- `pm_00`, `pm_01`, `pm_10`, `pm_11` in PM_W each: new path metrics from the ACS.
- `norm_en` out 1: one-cycle strobe; the ACS subtracts `norm_val` from all metrics.
- `norm_val` out PM_W: amount to subtract.
- `step_cnt` out clog2(FRAME_LEN): index of the current or last issued step.
- `tb_start` out 1: one-cycle traceback trigger.
- `tb_done` in 1: traceback complete pulse.
- `frame_done` out 1: one-cycle pulse at frame completion.

## Operation
States: IDLE, ISSUE, WAIT_ACS, NORM, TRACEBACK.
- **IDLE**
  - `sym_ready`=1.
  - On `sym_valid`: latch `sym_data` into `bmu_sym` and go to ISSUE.
- **ISSUE**
  - `bmu_valid`=1 for exactly one cycle; `first_step`=(step_cnt==0).
  - Go to WAIT_ACS.
- **WAIT_ACS**
  - Wait indefinitely for `acs_done`.
  - On `acs_done`: latch the four `pm_*` inputs and go to NORM.
  - `acs_done` in any other state is ignored.
- **NORM**
  - Single cycle.
  - If max(latched pm) ≥ NORM_THRESH: `norm_en`=1 and `norm_val`=min(latched pm); otherwise `norm_en`=0.
  - Subtracting the minimum never underflows.
  - Then:
    - If step_cnt==FRAME_LEN-1: go to TRACEBACK with `tb_start`=1 for one cycle.
    - Else: step_cnt+1 and return to IDLE.
- **TRACEBACK**
  - `sym_ready`=0.
  - On `tb_done`: `frame_done`=1 for one cycle, step_cnt wraps to 0, go to IDLE.
  - `tb_done` sampled in the same cycle that `tb_start` is asserted is ignored.
- Min/max use unsigned PM_W compares. Ties are irrelevant, since only the value is used.
- `sym_ready` is 0 in every state except IDLE. No symbol is ever dropped or duplicated.

## Timing
- Reset (`rst_n`=0 at a rising edge): state=IDLE, step_cnt=0.
- Every output is 0 at reset except `sym_ready`, which is 1 from the first cycle after reset releases. `bmu_sym`=0 and `norm_val`=0.
- Reset asserted mid-frame aborts the frame. No `tb_start` or `frame_done` is produced, and the next accepted symbol is step 0.
- Latency from accept edge to the `bmu_valid` cycle: 1 cycle.
- Step period with `acs_done` returning k cycles after `bmu_valid` is k+3 cycles: accept, ISSUE, k WAIT cycles, NORM.
- Minimum step period is 4 cycles (k=1).
- `tb_start` is registered out of NORM. `frame_done` is asserted the cycle after `tb_done` is sampled.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `VITERBI_NORM_EN` defined:
  - Normalisation logic as described above.
- Not defined:
  - `norm_en` and `norm_val` are tied to 0 and no min/max compare logic is built.
  - The NORM state remains a single pass-through cycle, so step timing is identical in both builds.

## Test plan
- **Single frame, FRAME_LEN=8, `acs_done` 1 cycle after `bmu_valid`, metrics all ≤5:**
  - 8 `bmu_valid` pulses.
  - `first_step`=1 only on the first.
  - `norm_en` never asserts.
  - `tb_start` once after step 7.
  - Accept edges exactly 4 cycles apart.
- **Normalisation, metrics 13/9/14/10 returned on step 2:**
  - `norm_en`=1 with `norm_val`=9.
  - With metrics 11/3/4/7, `norm_en`=0.
  - Without `VITERBI_NORM_EN`, `norm_en` stays 0 in both cases.
- **Backpressure:**
  - `sym_valid` held high throughout traceback with `tb_done` delayed 20 cycles: `sym_ready`=0 for all 20 cycles.
  - `frame_done` pulses once.
  - The next symbol is accepted as step 0 with `first_step`=1.
- **Stray handshakes:**
  - `acs_done` pulsed in IDLE and in ISSUE is ignored.
  - `tb_done` pulsed mid-frame is ignored.
  - step_cnt and state are unaffected.
- **Reset mid-frame:**
  - `rst_n` low for 1 cycle during WAIT_ACS at step 5.
  - All outputs return to reset values (`sym_ready`=1).
  - No `tb_start` is produced.
  - The following frame starts at step 0.
- **Slow ACS:**
  - `acs_done` delayed 6 cycles: `bmu_valid` is not re-issued.
  - Step period is 9 cycles.
  - `bmu_sym` stays stable until the next accept.
